cacheline_adaptor: RTL and testbench
====================================

# cacheline_adaptor

Converts 256-bit cache-line transactions into 4-beat, 64-bit memory bursts. Sits directly downstream of the I/D-cache arbiter: its line side takes the arbiter's adaptor_* outputs and returns the response and read data. Its burst side drives physical memory.

## Interface
- No parameters. Line width is 256 bits, beat width is 64 bits, burst length is 4, and line size is 32 bytes. All of these are fixed.
- clk  input  1  system clock; all state updates on rising edge
- rst  input  1  reset; asynchronous, active-high
- line_i  input  256  write line from the arbiter (adaptor_wdata)
- line_o  output  256  assembled read line to the arbiter (adaptor_rdata)
- address_i  input  32  line address from the arbiter (adaptor_address)
- read_i  input  1  line read request (adaptor_read)
- write_i  input  1  line write request (adaptor_write)
- resp_o  output  1  one-cycle completion pulse (adaptor_resp)
- burst_i  input  64  read beat from memory
- burst_o  output  64  write beat to memory
- address_o  output  32  burst address to memory, 32-byte aligned
- read_o  output  1  memory read request
- write_o  output  1  memory write request
- resp_i  input  1  memory beat strobe; one beat is transferred per cycle in which this is high

## Operation
- States: IDLE, RD, WR, DONE. There is a 2-bit beat counter and two registers, line_q (256) and addr_q (32).
- IDLE
  - If read_i is high: latch addr_q = {address_i[31:5], 5'b0}, clear the counter, go to RD.
  - Else if write_i is high: latch addr_q as above, latch line_q = line_i, clear the counter, go to WR.
  - If both are high, read wins and the write is ignored. The arbiter never drives both.
- RD: read_o = 1. On each cycle with resp_i = 1, write line_q[64*cnt +: 64] = burst_i and increment cnt. On the beat where cnt == 3, go to DONE.
- WR: write_o = 1 and burst_o = line_q[64*cnt +: 64]. On each cycle with resp_i = 1, increment cnt. On the beat where cnt == 3, go to DONE.
- DONE: resp_o = 1 for exactly one cycle, then go to IDLE.
- Beat order is little-endian: beat 0 carries bits [63:0] and beat 3 carries bits [255:192].
- Gaps are allowed: cycles in RD or WR with resp_i = 0 hold the counter and all outputs.
- address_o = addr_q whenever read_o or write_o is high; otherwise it is 0.
- line_o = line_q at all times. After a read it is stable from the DONE cycle until the next accepted request.
- Changes on read_i, write_i, address_i or line_i after acceptance are ignored until the block returns to IDLE.
- resp_i outside RD and WR is ignored.

## Timing
- Reset (asynchronous, takes effect immediately):
  - State goes to IDLE and cnt to 0.
  - read_o, write_o and resp_o go to 0.
  - address_o, burst_o and line_o go to 0, and line_q and addr_q are cleared.
  - Any in-flight burst is abandoned with no resp_o.
- Request accepted at edge T (IDLE, read_i or write_i high): read_o or write_o is high from cycle T+1.
- Beats: with 4 consecutive resp_i cycles at T+k..T+k+3, read_o or write_o drops at T+k+4. That same cycle is DONE, with resp_o = 1.
- Minimum latency, from the accept cycle to the resp_o cycle, is 5 cycles when memory returns resp_i in the first cycle the request is visible.
- After DONE, IDLE samples requests in the next cycle. The caller must drop read_i and write_i in the cycle after it sees resp_o. A request still high at that point is treated as a new transaction.
- burst_o changes only on a beat-accept edge, so it is stable whenever resp_i is sampled.
- No combinational path exists from resp_i to any output. All outputs are decodes of registered state.

## Test plan
- Read, contiguous:
  - Stimulus: address_i = 0x1234_5678 with read_i; memory returns beats 0x11..11, 0x22..22, 0x33..33, 0x44..44 on 4 consecutive cycles.
  - Response: address_o = 0x1234_5660; line_o = {0x44..44, 0x33..33, 0x22..22, 0x11..11}; resp_o high for 1 cycle, 5 cycles after accept.
- Write:
  - Stimulus: line_i = 256'h0003…0002…0001…0000 (beat n = n) with write_i.
  - Response: burst_o = 0, 1, 2, 3 on successive resp_i cycles; write_o low after the 4th beat; single resp_o; read_o never high.
- Gapped read: resp_i pattern 1,0,0,1,1,0,1. Exactly 4 beats are captured in order, read_o is held through the gaps, and resp_o fires once after the 7th cycle.
- Request noise: toggle address_i and line_i, and deassert read_i mid-burst. The burst uses the latched values and completes normally.
- Reset mid-write: assert rst after beat 2. All outputs are 0 at once, with no resp_o. A subsequent read completes normally from beat 0.
- Simultaneous read_i and write_i in IDLE, plus a stray resp_i while IDLE. A read burst is performed and the stray strobe changes no state.

Source files
------------

// File: rtl/cacheline_adaptor.sv
// Bridges 256-bit cache-line reads/writes from the arbiter to 4-beat 64-bit
// memory bursts. Beat 0 carries line bits [63:0] (little-endian beat order).
module cacheline_adaptor (
   input  logic         clk,
   input  logic         rst,
   input  logic [255:0] line_i,
   output logic [255:0] line_o,
   input  logic [31:0]  address_i,
   input  logic         read_i,
   input  logic         write_i,
   output logic         resp_o,
   input  logic [63:0]  burst_i,
   output logic [63:0]  burst_o,
   output logic [31:0]  address_o,
   output logic         read_o,
   output logic         write_o,
   input  logic         resp_i
);

   typedef enum logic [1:0] {IDLE, RD, WR, DONE} state_t;

   state_t         state_q, state_d;
   logic [1:0]     cnt_q, cnt_d;
   logic [255:0]   line_q, line_d;
   logic [31:0]    addr_q, addr_d;

   // NOTE: sequential state uses non-blocking assignments only, so every
   // register samples the pre-edge value of every other register.
   // NOTE: line_q is a plain register, not a memory; it is reset because
   // line_o must read as zero immediately after reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         line_q  <= '0;
         addr_q  <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         line_q  <= line_d;
         addr_q  <= addr_d;
      end
   end

   // NOTE: every variable gets its hold value first so no path infers a latch.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      line_d  = line_q;
      addr_d  = addr_q;
      case (state_q)
         IDLE: begin
            // Read has priority; a simultaneous write is dropped.
            if (read_i) begin
               addr_d  = {address_i[31:5], 5'b0};
               cnt_d   = '0;
               state_d = RD;
            end else if (write_i) begin
               addr_d  = {address_i[31:5], 5'b0};
               line_d  = line_i;
               cnt_d   = '0;
               state_d = WR;
            end
         end
         RD: begin
            if (resp_i) begin
               line_d[{cnt_q, 6'b0} +: 64] = burst_i;
               cnt_d = cnt_q + 2'd1;
               if (cnt_q == 2'd3) state_d = DONE;
            end
         end
         WR: begin
            if (resp_i) begin
               cnt_d = cnt_q + 2'd1;
               if (cnt_q == 2'd3) state_d = DONE;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // All outputs decode registered state; resp_i never reaches them directly.
   assign read_o    = (state_q == RD);
   assign write_o   = (state_q == WR);
   assign resp_o    = (state_q == DONE);
   assign address_o = (read_o || write_o) ? addr_q : 32'h0;
   assign burst_o   = write_o ? line_q[{cnt_q, 6'b0} +: 64] : 64'h0;
   assign line_o    = line_q;

endmodule

// File: tb/tb_cacheline_adaptor.sv
// Directed bench for cacheline_adaptor: inputs change and outputs are checked
// 1 ns after each rising edge.
module tb_cacheline_adaptor;

   logic         clk = 1'b0;
   logic         rst;
   logic [255:0] line_i, line_o;
   logic [31:0]  address_i, address_o;
   logic         read_i, write_i, resp_o;
   logic [63:0]  burst_i, burst_o;
   logic         read_o, write_o, resp_i;

   int n_cmp  = 0;
   int n_fail = 0;

   logic [63:0]  beat [4];
   logic [255:0] exp_line;

   cacheline_adaptor dut (
      .clk       (clk),
      .rst       (rst),
      .line_i    (line_i),
      .line_o    (line_o),
      .address_i (address_i),
      .read_i    (read_i),
      .write_i   (write_i),
      .resp_o    (resp_o),
      .burst_i   (burst_i),
      .burst_o   (burst_o),
      .address_o (address_o),
      .read_o    (read_o),
      .write_o   (write_o),
      .resp_i    (resp_i)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] expv);
      n_cmp++;
      assert (obs === expv) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, expv);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_idle_outs(input string tag);
      check({tag, " read_o"},    256'(read_o),    256'(0));
      check({tag, " write_o"},   256'(write_o),   256'(0));
      check({tag, " address_o"}, 256'(address_o), 256'(0));
      check({tag, " burst_o"},   256'(burst_o),   256'(0));
   endtask

   initial begin
      rst = 1'b0; line_i = '0; address_i = '0; read_i = 1'b0; write_i = 1'b0;
      burst_i = '0; resp_i = 1'b0;
      #1 rst = 1'b1;
      #2;
      check_idle_outs("reset");
      check("reset resp_o", 256'(resp_o), 256'(0));
      check("reset line_o", line_o, 256'(0));
      tick(); tick();
      rst = 1'b0;
      tick();

      // ---- contiguous read ----
      for (int i = 0; i < 4; i++) beat[i] = 64'h1111_1111_1111_1111 * 64'(i + 1);
      address_i = 32'h1234_5678; read_i = 1'b1;
      check("rd idle read_o", 256'(read_o), 256'(0));
      tick();
      read_i = 1'b0;
      check("rd address_o", 256'(address_o), 256'(32'h1234_5660));
      for (int i = 0; i < 4; i++) begin
         check("rd read_o held", 256'(read_o), 256'(1));
         check("rd no early resp", 256'(resp_o), 256'(0));
         resp_i = 1'b1; burst_i = beat[i];
         tick();
      end
      resp_i = 1'b0; burst_i = '0;
      check("rd resp_o at T+5", 256'(resp_o), 256'(1));
      check("rd read_o dropped", 256'(read_o), 256'(0));
      check("rd address_o idle", 256'(address_o), 256'(0));
      check("rd line_o", line_o, {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                                  64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111});
      tick();
      check("rd resp_o one cycle", 256'(resp_o), 256'(0));
      check("rd line_o stable", line_o, {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                                         64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111});

      // ---- write ----
      line_i = {64'd3, 64'd2, 64'd1, 64'd0}; address_i = 32'h0000_101F; write_i = 1'b1;
      tick();
      write_i = 1'b0; line_i = '1;
      check("wr address_o", 256'(address_o), 256'(32'h0000_1000));
      for (int i = 0; i < 4; i++) begin
         check("wr write_o", 256'(write_o), 256'(1));
         check("wr read_o never", 256'(read_o), 256'(0));
         check("wr burst_o beat", 256'(burst_o), 256'(i));
         resp_i = 1'b1;
         tick();
      end
      resp_i = 1'b0;
      check("wr write_o dropped", 256'(write_o), 256'(0));
      check("wr resp_o", 256'(resp_o), 256'(1));
      check("wr burst_o idle", 256'(burst_o), 256'(0));
      tick();
      check("wr resp_o one cycle", 256'(resp_o), 256'(0));

      // ---- gapped read: resp_i 1,0,0,1,1,0,1 ----
      beat[0] = 64'hA0A0_0000_0000_00A0; beat[1] = 64'hB1B1_0000_0000_00B1;
      beat[2] = 64'hC2C2_0000_0000_00C2; beat[3] = 64'hD3D3_0000_0000_00D3;
      address_i = 32'h0000_00FF; read_i = 1'b1;
      tick();
      read_i = 1'b0;
      check("gap address_o", 256'(address_o), 256'(32'h0000_00E0));
      begin
         logic [6:0] pat;
         int b;
         pat = 7'b1011001;   // bit 0 is the first cycle
         b = 0;
         for (int c = 0; c < 7; c++) begin
            check("gap read_o held", 256'(read_o), 256'(1));
            check("gap no early resp", 256'(resp_o), 256'(0));
            resp_i = pat[c];
            burst_i = pat[c] ? beat[b] : 64'hDEAD_BEEF_DEAD_BEEF;
            if (pat[c]) b++;
            tick();
         end
      end
      resp_i = 1'b0;
      check("gap resp_o", 256'(resp_o), 256'(1));
      check("gap line_o", line_o, {64'hD3D3_0000_0000_00D3, 64'hC2C2_0000_0000_00C2,
                                   64'hB1B1_0000_0000_00B1, 64'hA0A0_0000_0000_00A0});
      tick();
      check("gap resp_o one cycle", 256'(resp_o), 256'(0));

      // ---- request noise during a read ----
      address_i = 32'h8000_0040; read_i = 1'b1;
      tick();
      for (int i = 0; i < 4; i++) begin
         if (i == 1) read_i = 1'b0;
         address_i = 32'hFFFF_FFFF - 32'(i * 7);
         line_i = {4{64'(i) ^ 64'h5A5A_5A5A_5A5A_5A5A}};
         check("noise address_o latched", 256'(address_o), 256'(32'h8000_0040));
         check("noise read_o held", 256'(read_o), 256'(1));
         resp_i = 1'b1; burst_i = 64'h0F00_0000_0000_0000 + 64'(i);
         tick();
      end
      resp_i = 1'b0;
      check("noise resp_o", 256'(resp_o), 256'(1));
      check("noise line_o", line_o, {64'h0F00_0000_0000_0003, 64'h0F00_0000_0000_0002,
                                     64'h0F00_0000_0000_0001, 64'h0F00_0000_0000_0000});
      tick();

      // ---- reset mid-write ----
      line_i = {64'hEEEE_0003, 64'hEEEE_0002, 64'hEEEE_0001, 64'hEEEE_0000};
      address_i = 32'h0000_0040; write_i = 1'b1;
      tick();
      write_i = 1'b0;
      for (int i = 0; i < 2; i++) begin
         resp_i = 1'b1;
         tick();
      end
      resp_i = 1'b0;
      check("rst-wr burst_o beat2", 256'(burst_o), 256'(64'hEEEE_0002));
      rst = 1'b1;
      #1;
      check_idle_outs("rst-wr async");
      check("rst-wr resp_o", 256'(resp_o), 256'(0));
      check("rst-wr line_o", line_o, 256'(0));
      tick();
      check("rst-wr resp_o held", 256'(resp_o), 256'(0));
      rst = 1'b0;
      tick();
      check("rst-wr resp_o after", 256'(resp_o), 256'(0));
      for (int i = 0; i < 4; i++) beat[i] = 64'h7700_0000_0000_0000 + 64'(i);
      address_i = 32'h0000_0100; read_i = 1'b1;
      tick();
      read_i = 1'b0;
      check("post-rst address_o", 256'(address_o), 256'(32'h0000_0100));
      for (int i = 0; i < 4; i++) begin
         resp_i = 1'b1; burst_i = beat[i];
         tick();
      end
      resp_i = 1'b0;
      exp_line = {beat[3], beat[2], beat[1], beat[0]};
      check("post-rst resp_o", 256'(resp_o), 256'(1));
      check("post-rst line_o", line_o, exp_line);
      tick();

      // ---- stray resp_i in IDLE, then simultaneous read/write ----
      resp_i = 1'b1; burst_i = 64'hBAD0_BAD0_BAD0_BAD0;
      tick();
      resp_i = 1'b0;
      check_idle_outs("stray");
      check("stray resp_o", 256'(resp_o), 256'(0));
      check("stray line_o", line_o, exp_line);
      address_i = 32'h2000_0010; line_i = {4{64'hFACE_FACE_FACE_FACE}};
      read_i = 1'b1; write_i = 1'b1;
      tick();
      read_i = 1'b0; write_i = 1'b0;
      check("both read_o", 256'(read_o), 256'(1));
      check("both write_o", 256'(write_o), 256'(0));
      check("both address_o", 256'(address_o), 256'(32'h2000_0000));
      for (int i = 0; i < 4; i++) begin
         resp_i = 1'b1; burst_i = 64'h0000_0000_CAFE_0000 + 64'(i);
         tick();
      end
      resp_i = 1'b0;
      check("both resp_o", 256'(resp_o), 256'(1));
      check("both line_o", line_o, {64'h0000_0000_CAFE_0003, 64'h0000_0000_CAFE_0002,
                                    64'h0000_0000_CAFE_0001, 64'h0000_0000_CAFE_0000});
      tick();
      check("final resp_o", 256'(resp_o), 256'(0));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
